onewire_slave_responder: RTL
============================

# onewire_slave_responder

Slave-side responder for the One Wire bus. It detects the master's reset pulse, answers with a presence pulse, and then receives the master's first command byte from eight write time slots. It sits on the device side of the same open-drain bus that the master's presence waiter samples, and gives the team a synthesizable slave for loop-back benches and device emulation. All timing is in clk ticks; one tick is 1 us.

## Interface
- RESET_MIN, 480, minimum continuous bus-low ticks that qualify as a master reset
- PRES_WAIT, 30, ticks from reset release to the start of the presence drive (15..60 legal)
- PRES_LEN, 120, ticks the presence pulse is driven low (60..240 legal)
- SAMPLE_AT, 30, tick within a write slot, counted from its falling edge, at which the bit is sampled
- CNT_W, 10, width of the tick counters; must hold RESET_MIN
- clk  in  1  system clock, 1 us per tick
- rst_n  in  1  asynchronous active-low reset
- bus  in  1  sensed open-drain bus level
- en  in  1  responder enable; low forces IDLE and releases the bus
- slave_pull_low  out  1  1 = drive bus low (presence pulse)
- reset_seen  out  1  one-cycle pulse when a valid master reset ends
- presence_sent  out  1  one-cycle pulse when the presence drive ends
- cmd_byte  out  8  last received byte, LSB first on the wire
- cmd_valid  out  1  one-cycle pulse; cmd_byte is updated in the same cycle

## Operation
- States: IDLE, RST_LOW, PRES_WAIT, PRES_DRIVE, PRES_REL, SLOT_IDLE, SLOT_SAMPLE, SLOT_END.
- Low counter: counts consecutive cycles with the bus low and saturates at RESET_MIN. It clears when the bus is high. It is frozen at 0 in PRES_DRIVE so the slave's own drive is never treated as a reset.
- In any state except PRES_DRIVE, the low counter reaching RESET_MIN moves the block to RST_LOW. This restarts the sequence mid-byte and clears the bit counter.
- IDLE: a bus-low pulse shorter than RESET_MIN is ignored.
- RST_LOW: waits for the bus to go high. On the first high cycle: reset_seen=1 and the block moves to PRES_WAIT with the tick counter at 0.
- PRES_WAIT: after PRES_WAIT ticks, moves to PRES_DRIVE with slave_pull_low=1.
- PRES_DRIVE: after PRES_LEN ticks: slave_pull_low=0, presence_sent=1, move to PRES_REL.
- PRES_REL: waits for the bus to go high, then moves to SLOT_IDLE.
- SLOT_IDLE: a falling edge (previous sample high, current sample low) moves the block to SLOT_SAMPLE with the tick counter at 1.
- SLOT_SAMPLE: at tick SAMPLE_AT, shifts in the bus level (0 = write-0, 1 = write-1) at the MSB end of the shift register, then moves to SLOT_END.
- SLOT_END: waits for the bus to go high, then returns to SLOT_IDLE.
- Byte completion: after the 8th bit, cmd_byte <= shift register, cmd_valid=1, and the block goes to IDLE. Later slots are ignored until the next reset.
- en=0: the next cycle is IDLE, with slave_pull_low=0 and the counters cleared. cmd_byte is held.
- No transmit (read-slot) support. slave_pull_low is asserted only in PRES_DRIVE.

## Timing
- Reset values: state=IDLE, slave_pull_low=0, reset_seen=0, presence_sent=0, cmd_valid=0, cmd_byte=8'h00, all counters 0.
- rst_n assertion mid-presence releases the bus immediately (asynchronous).
- Presence drive starts PRES_WAIT+1 cycles after the first high sample following the reset, and lasts exactly PRES_LEN cycles.
- All outputs are registered.
- The bus-to-decision latency is 0 cycles without the synchronizer and 2 cycles with it. All latencies above add this figure.
- Simultaneous cases:
  - Reset qualification on the same cycle as a slot sample: the reset wins and the bit is discarded.
  - Bus high on the same cycle the low counter reaches RESET_MIN: the reset is valid.

## Configuration
- ONEWIRE_SLAVE_BUS_SYNC_EN
  - Defined: bus passes through a two-flop synchronizer, reset to 1, before all logic; adds 2 cycles latency.
  - Undefined: bus is used directly; the bench must drive it synchronously.

## Structure
- Shared package onewire_pkg: the state enum, default timing constants (RESET_MIN, PRES_WAIT, PRES_LEN, SAMPLE_AT) and the 1-tick-per-us note.
- Sub-module onewire_bus_sync: optional synchronizer plus previous-sample register; outputs bus_s and fall.

## Test plan
- Bus low 480 ticks, then released: reset_seen on the first high cycle; slave_pull_low high for exactly 120 cycles starting 31 cycles later; then presence_sent.
- Bus low 479 ticks, then released: no reset_seen, no pull.
- Full sequence, then 8 slots writing 8'hCC LSB first (write-0 = low 60 ticks, write-1 = low 5 ticks): cmd_valid once, cmd_byte=8'hCC.
- After 3 slots, bus low 500 ticks: reset_seen, a new presence pulse, and the next 8 slots yield a fresh byte with no stale bits.
- en dropped 50 ticks into PRES_DRIVE: slave_pull_low=0 next cycle and state IDLE; rst_n low mid-drive releases the bus asynchronously.
- With ONEWIRE_SLAVE_BUS_SYNC_EN: repeat the first scenario; every event shifts by exactly 2 cycles.

Source files
------------

// File: rtl/onewire_pkg.sv
// onewire_pkg: shared types and default timing for the One Wire slave.
// Timing unit: one clk tick = 1 us, so all constants are in microseconds.
package onewire_pkg;

    localparam int RESET_MIN = 480;
    localparam int PRES_WAIT = 30;
    localparam int PRES_LEN  = 120;
    localparam int SAMPLE_AT = 30;
    localparam int CNT_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_PRES_WAIT,
        ST_PRES_DRIVE,
        ST_PRES_REL,
        ST_SLOT_IDLE,
        ST_SLOT_SAMPLE,
        ST_SLOT_END
    } ow_state_e;

endpackage

// File: rtl/onewire_slave_responder_if.sv
// onewire_slave_responder_if: bus sense/drive and status bundle.
// slave: bus, en in; slave_pull_low, reset_seen, presence_sent, cmd_byte, cmd_valid out.
interface onewire_slave_responder_if;

    logic       bus;
    logic       en;
    logic       slave_pull_low;
    logic       reset_seen;
    logic       presence_sent;
    logic [7:0] cmd_byte;
    logic       cmd_valid;

    modport slave (
        input  bus,
        input  en,
        output slave_pull_low,
        output reset_seen,
        output presence_sent,
        output cmd_byte,
        output cmd_valid
    );

    modport master (
        output bus,
        output en,
        input  slave_pull_low,
        input  reset_seen,
        input  presence_sent,
        input  cmd_byte,
        input  cmd_valid
    );

endinterface

// File: rtl/onewire_bus_sync.sv
// onewire_bus_sync: optional 2-flop bus synchronizer plus previous-sample edge detect.
// Ports: clk, rst_n, bus in; bus_s (sensed level), fall (high->low) out. Macro: ONEWIRE_SLAVE_BUS_SYNC_EN.
module onewire_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bus,
    output logic bus_s,
    output logic fall
);

`ifdef ONEWIRE_SLAVE_BUS_SYNC_EN
    logic [1:0] sync_q;

    // Resets to the idle (released) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus};
        end
    end

    assign bus_s = sync_q[1];
`else
    assign bus_s = bus;
`endif

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= bus_s;
        end
    end

    assign fall = prev_q & ~bus_s;

endmodule

// File: rtl/onewire_slave_responder.sv
// onewire_slave_responder: detects master reset, sends presence, receives first command byte.
// Ports: clk, rst_n; ow (slave modport: bus, en, slave_pull_low, reset_seen, presence_sent,
// cmd_byte, cmd_valid). Macro ONEWIRE_SLAVE_BUS_SYNC_EN adds a 2-cycle bus synchronizer.
module onewire_slave_responder #(
    parameter int RESET_MIN = onewire_pkg::RESET_MIN,
    parameter int PRES_WAIT = onewire_pkg::PRES_WAIT,
    parameter int PRES_LEN  = onewire_pkg::PRES_LEN,
    parameter int SAMPLE_AT = onewire_pkg::SAMPLE_AT,
    parameter int CNT_W     = onewire_pkg::CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    onewire_slave_responder_if.slave   ow
);

    import onewire_pkg::*;

    localparam logic [CNT_W-1:0] RMIN = CNT_W'(RESET_MIN);
    localparam logic [CNT_W-1:0] PWT  = CNT_W'(PRES_WAIT);
    localparam logic [CNT_W-1:0] PLN  = CNT_W'(PRES_LEN);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    ow_state_e        state_q, state_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [7:0]       byte_q, byte_d;
    logic             pull_q, pull_d;
    logic             rs_q, rs_d;
    logic             ps_q, ps_d;
    logic             cv_q, cv_d;

    logic             bus_s;
    logic             fall;
    logic             rst_hit;
    logic [7:0]       shifted;

    onewire_bus_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ow.bus),
        .bus_s (bus_s),
        .fall  (fall)
    );

    // Our own presence drive must never look like a master reset.
    assign rst_hit = (state_q != ST_PRES_DRIVE) && (lcnt_q == RMIN);
    // Wire order is LSB first, so new bits enter at the MSB end.
    assign shifted = {bus_s, sreg_q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sreg_q  <= '0;
            byte_q  <= '0;
            pull_q  <= 1'b0;
            rs_q    <= 1'b0;
            ps_q    <= 1'b0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sreg_q  <= sreg_d;
            byte_q  <= byte_d;
            pull_q  <= pull_d;
            rs_q    <= rs_d;
            ps_q    <= ps_d;
            cv_q    <= cv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        sreg_d  = sreg_q;
        byte_d  = byte_q;
        pull_d  = pull_q;
        rs_d    = 1'b0;
        ps_d    = 1'b0;
        cv_d    = 1'b0;

        if (state_q == ST_PRES_DRIVE || bus_s) begin
            lcnt_d = '0;
        end else if (lcnt_q != RMIN) begin
            lcnt_d = lcnt_q + ONE;
        end

        if (!ow.en) begin
            state_d = ST_IDLE;
            lcnt_d  = '0;
            tcnt_d  = '0;
            bcnt_d  = '0;
            sreg_d  = '0;
            pull_d  = 1'b0;
        end else if (rst_hit) begin
            // A qualified reset beats any slot activity this cycle.
            bcnt_d = '0;
            sreg_d = '0;
            tcnt_d = '0;
            pull_d = 1'b0;
            if (bus_s) begin
                rs_d    = 1'b1;
                state_d = ST_PRES_WAIT;
            end else begin
                state_d = ST_RST_LOW;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_RST_LOW: begin
                    if (bus_s) begin
                        rs_d    = 1'b1;
                        tcnt_d  = '0;
                        state_d = ST_PRES_WAIT;
                    end
                end
                ST_PRES_WAIT: begin
                    if (tcnt_q == PWT) begin
                        pull_d  = 1'b1;
                        tcnt_d  = ONE;
                        state_d = ST_PRES_DRIVE;
                    end else begin
                        tcnt_d = tcnt_q + ONE;
                    end
                end
                ST_PRES_DRIVE: begin
                    if (tcnt_q == PLN) begin
                        pull_d  = 1'b0;
                        ps_d    = 1'b1;
                        tcnt_d  = '0;
                        state_d = ST_PRES_REL;
                    end else begin
                        tcnt_d = tcnt_q + ONE;
                    end
                end
                ST_PRES_REL: begin
                    if (bus_s) begin
                        state_d = ST_SLOT_IDLE;
                    end
                end
                ST_SLOT_IDLE: begin
                    if (fall) begin
                        tcnt_d  = ONE;
                        state_d = ST_SLOT_SAMPLE;
                    end
                end
                ST_SLOT_SAMPLE: begin
                    if (tcnt_q == SAT) begin
                        sreg_d = shifted;
                        bcnt_d = bcnt_q + 3'd1;
                        tcnt_d = '0;
                        if (bcnt_q == 3'd7) begin
                            byte_d  = shifted;
                            cv_d    = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_SLOT_END;
                        end
                    end else begin
                        tcnt_d = tcnt_q + ONE;
                    end
                end
                ST_SLOT_END: begin
                    if (bus_s) begin
                        state_d = ST_SLOT_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign ow.slave_pull_low = pull_q;
    assign ow.reset_seen     = rs_q;
    assign ow.presence_sent  = ps_q;
    assign ow.cmd_byte       = byte_q;
    assign ow.cmd_valid      = cv_q;

endmodule
